// File: rtl/writeback_drain_ctrl.sv
// Writeback drain controller: pops one packet from the writeback buffer, holds it
// in a staging register, issues it to memory, and retries after a backoff on NACK.
// The held packet stays visible to an address probe until memory confirms the write.

`ifndef CPU_WORD_LEN_IN_BITS
`define CPU_WORD_LEN_IN_BITS 32
`endif
`ifndef MEM_PACKET_ADDR_POS_HI
`define MEM_PACKET_ADDR_POS_HI 31
`endif
`ifndef MEM_PACKET_ADDR_POS_LO
`define MEM_PACKET_ADDR_POS_LO 0
`endif

module writeback_drain_ctrl #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32,
    parameter int ADDR_LEN_IN_BITS           = `CPU_WORD_LEN_IN_BITS,
    parameter int RETRY_DELAY                = 4,
    parameter int BACKOFF_CNT_WIDTH          = 3,
    parameter int RETRY_CNT_WIDTH            = 8
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    input  logic                                  request_valid_in,
    output logic                                  issue_ack_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem_request_out,
    output logic                                  mem_request_valid_out,
    input  logic                                  mem_issue_ack_in,
    input  logic                                  mem_response_valid_in,
    input  logic                                  mem_response_nack_in,
    input  logic [ADDR_LEN_IN_BITS-1:0]           cam_address_in,
    output logic                                  inflight_hit_out,
    output logic                                  busy_out,
    output logic                                  writeback_done_out,
    output logic [RETRY_CNT_WIDTH-1:0]            retry_count_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        BACKOFF   = 2'd3
    } state_t;

    // Counter value is loaded with RETRY_DELAY on the NACK edge; leaving BACKOFF
    // when it reaches 2 puts the re-issue exactly RETRY_DELAY cycles after the NACK.
    localparam logic [BACKOFF_CNT_WIDTH-1:0] RETRY_LOAD   = BACKOFF_CNT_WIDTH'(RETRY_DELAY);
    localparam logic [BACKOFF_CNT_WIDTH-1:0] CNT_ISSUE_AT = BACKOFF_CNT_WIDTH'(2);
    localparam logic [RETRY_CNT_WIDTH-1:0]   RETRY_MAX    = {RETRY_CNT_WIDTH{1'b1}};

    state_t                                  state_r;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]   staging_r;
    logic [BACKOFF_CNT_WIDTH-1:0]            backoff_cnt_r;
    logic [RETRY_CNT_WIDTH-1:0]              retry_cnt_r;
    logic                                    mem_valid_r;
    logic                                    busy_r;
    logic                                    done_r;
    logic                                    pop_s;
    logic                                    hit_s;

    // Pop strobe: only in IDLE, and forced low while reset is asserted.
    always_comb begin
        pop_s = 1'b0;
        if ((state_r == IDLE) && !reset_in) begin
            pop_s = request_valid_in;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Address probe against the held packet; never hits when nothing is held.
    always_comb begin
        hit_s = 1'b0;
        if (busy_r) begin
            hit_s = (staging_r[`MEM_PACKET_ADDR_POS_HI:`MEM_PACKET_ADDR_POS_LO] == cam_address_in);
        end else begin
            hit_s = 1'b0;
        end
    end

    // Drain state machine with registered memory-side and status outputs.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_r       <= IDLE;
            staging_r     <= {SINGLE_ENTRY_WIDTH_IN_BITS{1'b0}};
            backoff_cnt_r <= {BACKOFF_CNT_WIDTH{1'b0}};
            retry_cnt_r   <= {RETRY_CNT_WIDTH{1'b0}};
            mem_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        staging_r   <= request_in;
                        state_r     <= ISSUE;
                        mem_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_issue_ack_in) begin
                        state_r     <= WAIT_RESP;
                        mem_valid_r <= 1'b0;
                    end
                end
                WAIT_RESP: begin
                    if (mem_response_valid_in) begin
                        if (mem_response_nack_in) begin
                            if (retry_cnt_r != RETRY_MAX) begin
                                retry_cnt_r <= retry_cnt_r + RETRY_CNT_WIDTH'(1'b1);
                            end
                            if (RETRY_DELAY <= 1) begin
                                state_r     <= ISSUE;
                                mem_valid_r <= 1'b1;
                            end else begin
                                state_r       <= BACKOFF;
                                backoff_cnt_r <= RETRY_LOAD;
                            end
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                BACKOFF: begin
                    backoff_cnt_r <= backoff_cnt_r - BACKOFF_CNT_WIDTH'(1'b1);
                    if (backoff_cnt_r <= CNT_ISSUE_AT) begin
                        state_r     <= ISSUE;
                        mem_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    mem_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign issue_ack_out         = pop_s;
    assign mem_request_out       = staging_r;
    assign mem_request_valid_out = mem_valid_r;
    assign inflight_hit_out      = hit_s;
    assign busy_out              = busy_r;
    assign writeback_done_out    = done_r;
    assign retry_count_out       = retry_cnt_r;

endmodule

// File: tb/tb_writeback_drain_ctrl.sv
// Bench for writeback_drain_ctrl: transaction-level model with a packet queue,
// per-cycle expected outputs derived from the handshake rules.

module tb_writeback_drain_ctrl;

    localparam int W           = 32;
    localparam int RETRY_DELAY = 4;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic [W-1:0]  request_in;
    logic          request_valid_in;
    logic          issue_ack_out;
    logic [W-1:0]  mem_request_out;
    logic          mem_request_valid_out;
    logic          mem_issue_ack_in;
    logic          mem_response_valid_in;
    logic          mem_response_nack_in;
    logic [31:0]   cam_address_in;
    logic          inflight_hit_out;
    logic          busy_out;
    logic          writeback_done_out;
    logic [7:0]    retry_count_out;

    writeback_drain_ctrl #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(W),
        .ADDR_LEN_IN_BITS(32),
        .RETRY_DELAY(RETRY_DELAY),
        .BACKOFF_CNT_WIDTH(3),
        .RETRY_CNT_WIDTH(8)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .request_in(request_in),
        .request_valid_in(request_valid_in),
        .issue_ack_out(issue_ack_out),
        .mem_request_out(mem_request_out),
        .mem_request_valid_out(mem_request_valid_out),
        .mem_issue_ack_in(mem_issue_ack_in),
        .mem_response_valid_in(mem_response_valid_in),
        .mem_response_nack_in(mem_response_nack_in),
        .cam_address_in(cam_address_in),
        .inflight_hit_out(inflight_hit_out),
        .busy_out(busy_out),
        .writeback_done_out(writeback_done_out),
        .retry_count_out(retry_count_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] pkt_q[$];
    logic [W-1:0] held_m = 32'h0;
    bit           in_flight = 1'b0;
    bit           done_pending = 1'b0;
    int           retry_model = 0;
    int           done_seen = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drive_req();
        if (pkt_q.size() > 0) begin
            request_valid_in = 1'b1;
            request_in       = pkt_q[0];
        end else begin
            request_valid_in = 1'b0;
            request_in       = 32'h0;
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic chk_cycle(input string tag, input bit exp_valid, input bit exp_busy, input bit exp_ack);
        bit exp_hit;
        cam_address_in = ($urandom_range(0, 1) == 1) ? held_m : (held_m ^ 32'h4);
        #1;
        exp_hit = in_flight && (cam_address_in == held_m);
        check({tag, ".ack"}, 64'(issue_ack_out), 64'(exp_ack));
        check({tag, ".valid"}, 64'(mem_request_valid_out), 64'(exp_valid));
        if (exp_valid) check({tag, ".pkt"}, 64'(mem_request_out), 64'(held_m));
        check({tag, ".busy"}, 64'(busy_out), 64'(exp_busy));
        check({tag, ".done"}, 64'(writeback_done_out), 64'(done_pending));
        check({tag, ".retry"}, 64'(retry_count_out), 64'(retry_model));
        check({tag, ".hit"}, 64'(inflight_hit_out), 64'(exp_hit));
        if (writeback_done_out) done_seen++;
    endtask

    // One full writeback: pop, issue with stalls, response with optional NACKs.
    task automatic run_txn(input string tag, input int stall, input int nacks, input int resp_delay);
        int vcount;
        vcount = 0;
        drive_req();
        mem_issue_ack_in      = 1'($urandom_range(0, 1));
        mem_response_valid_in = 1'($urandom_range(0, 1));
        mem_response_nack_in  = 1'($urandom_range(0, 1));
        chk_cycle({tag, ".pop"}, 1'b0, 1'b0, 1'b1);
        done_pending = 1'b0;
        held_m = pkt_q.pop_front();
        step();
        in_flight = 1'b1;
        drive_req();
        for (int a = 0; a <= nacks; a++) begin
            for (int s = 0; s < stall; s++) begin
                mem_issue_ack_in      = 1'b0;
                mem_response_valid_in = 1'($urandom_range(0, 1));
                mem_response_nack_in  = 1'($urandom_range(0, 1));
                chk_cycle({tag, ".stall"}, 1'b1, 1'b1, 1'b0);
                if (mem_request_valid_out) vcount++;
                step();
            end
            mem_issue_ack_in      = 1'b1;
            mem_response_valid_in = 1'($urandom_range(0, 1));
            mem_response_nack_in  = 1'($urandom_range(0, 1));
            chk_cycle({tag, ".issue"}, 1'b1, 1'b1, 1'b0);
            if (mem_request_valid_out) vcount++;
            step();
            for (int d = 0; d < resp_delay; d++) begin
                mem_issue_ack_in      = 1'($urandom_range(0, 1));
                mem_response_valid_in = 1'b0;
                mem_response_nack_in  = 1'($urandom_range(0, 1));
                chk_cycle({tag, ".wait"}, 1'b0, 1'b1, 1'b0);
                step();
            end
            mem_issue_ack_in      = 1'($urandom_range(0, 1));
            mem_response_valid_in = 1'b1;
            mem_response_nack_in  = (a < nacks);
            chk_cycle({tag, ".resp"}, 1'b0, 1'b1, 1'b0);
            step();
            mem_response_valid_in = 1'b0;
            mem_response_nack_in  = 1'b0;
            if (a < nacks) begin
                if (retry_model < 255) retry_model++;
                for (int b = 1; b < RETRY_DELAY; b++) begin
                    mem_issue_ack_in      = 1'($urandom_range(0, 1));
                    mem_response_valid_in = 1'($urandom_range(0, 1));
                    chk_cycle({tag, ".backoff"}, 1'b0, 1'b1, 1'b0);
                    step();
                end
                mem_response_valid_in = 1'b0;
            end else begin
                done_pending = 1'b1;
                in_flight    = 1'b0;
            end
        end
        mem_issue_ack_in = 1'b0;
        check({tag, ".valid_cycles"}, 64'(vcount), 64'((stall + 1) * (nacks + 1)));
    endtask

    // Idle cycle: nothing held, probe on the last address must miss.
    task automatic idle_check(input string tag);
        drive_req();
        mem_issue_ack_in      = 1'b0;
        mem_response_valid_in = 1'b0;
        mem_response_nack_in  = 1'b0;
        cam_address_in = held_m;
        #1;
        check({tag, ".ack"}, 64'(issue_ack_out), 64'(pkt_q.size() > 0));
        check({tag, ".valid"}, 64'(mem_request_valid_out), 64'(0));
        check({tag, ".busy"}, 64'(busy_out), 64'(0));
        check({tag, ".done"}, 64'(writeback_done_out), 64'(done_pending));
        check({tag, ".hit"}, 64'(inflight_hit_out), 64'(0));
        check({tag, ".retry"}, 64'(retry_count_out), 64'(retry_model));
        if (writeback_done_out) done_seen++;
        done_pending = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int done_before;
        reset_in              = 1'b1;
        request_in            = 32'h0;
        request_valid_in      = 1'b0;
        mem_issue_ack_in      = 1'b0;
        mem_response_valid_in = 1'b0;
        mem_response_nack_in  = 1'b0;
        cam_address_in        = 32'h0;
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst.ack", 64'(issue_ack_out), 64'(0));
        check("rst.valid", 64'(mem_request_valid_out), 64'(0));
        check("rst.pkt", 64'(mem_request_out), 64'(0));
        check("rst.busy", 64'(busy_out), 64'(0));
        check("rst.done", 64'(writeback_done_out), 64'(0));
        check("rst.retry", 64'(retry_count_out), 64'(0));
        check("rst.hit", 64'(inflight_hit_out), 64'(0));
        reset_in = 1'b0;
        step();
        idle_check("idle0");

        // Single pass, address 0x40
        pkt_q.push_back(32'h0000_0040);
        run_txn("t1", 0, 0, 0);
        idle_check("t1.end");

        // Memory stall of 5 cycles
        pkt_q.push_back($urandom);
        run_txn("t2", 5, 0, 1);
        idle_check("t2.end");

        // One NACK then success
        pkt_q.push_back($urandom);
        run_txn("t3", 0, 1, 0);
        idle_check("t3.end");
        check("t3.retry_count", 64'(retry_count_out), 64'(1));

        // Probe on held address 0x1000
        pkt_q.push_back(32'h0000_1000);
        run_txn("t4", 1, 0, 2);
        idle_check("t4.end");

        // Three back-to-back packets kept valid throughout
        done_before = done_seen;
        for (int i = 0; i < 3; i++) pkt_q.push_back($urandom);
        for (int i = 0; i < 3; i++) run_txn("t5", int'($urandom_range(0, 1)), 0, 0);
        idle_check("t5.end");
        check("t5.done_pulses", 64'(done_seen - done_before), 64'(3));

        // Randomised transactions, some chained
        for (int i = 0; i < 8; i++) begin
            pkt_q.push_back($urandom);
            if ($urandom_range(0, 1) == 1) pkt_q.push_back($urandom);
            while (pkt_q.size() > 0)
                run_txn("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            idle_check("rnd.end");
        end

        // Asynchronous reset while in BACKOFF
        pkt_q.push_back($urandom);
        drive_req();
        chk_cycle("t6.pop", 1'b0, 1'b0, 1'b1);
        held_m = pkt_q.pop_front();
        step();
        in_flight = 1'b1;
        drive_req();
        mem_issue_ack_in = 1'b1;
        chk_cycle("t6.issue", 1'b1, 1'b1, 1'b0);
        step();
        mem_issue_ack_in      = 1'b0;
        mem_response_valid_in = 1'b1;
        mem_response_nack_in  = 1'b1;
        chk_cycle("t6.nack", 1'b0, 1'b1, 1'b0);
        step();
        mem_response_valid_in = 1'b0;
        mem_response_nack_in  = 1'b0;
        if (retry_model < 255) retry_model++;
        chk_cycle("t6.backoff", 1'b0, 1'b1, 1'b0);
        #2;
        reset_in       = 1'b1;
        cam_address_in = held_m;
        #1;
        check("t6.ack", 64'(issue_ack_out), 64'(0));
        check("t6.valid", 64'(mem_request_valid_out), 64'(0));
        check("t6.pkt", 64'(mem_request_out), 64'(0));
        check("t6.busy", 64'(busy_out), 64'(0));
        check("t6.done", 64'(writeback_done_out), 64'(0));
        check("t6.retry", 64'(retry_count_out), 64'(0));
        check("t6.hit", 64'(inflight_hit_out), 64'(0));
        retry_model = 0;
        in_flight   = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b0;
        step();
        idle_check("t6.after");

        // Normal operation after reset
        pkt_q.push_back($urandom);
        run_txn("t7", 2, 1, 1);
        idle_check("t7.end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
